// File: rtl/mips_multicycle_control.sv
// ============================================================================
//  Module      : mips_multicycle_control
//  Description : Moore sequencer and ALU decoder for a multicycle MIPS datapath
//                (lw, sw, R-type, beq, addi).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               PCen,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               PCsrc,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal_o
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 'd0,
        S_DECODE   = 'd1,
        S_MEMADR   = 'd2,
        S_MEMRD    = 'd3,
        S_MEMWB    = 'd4,
        S_MEMWR    = 'd5,
        S_EXECUTE  = 'd6,
        S_ALUWB    = 'd7,
        S_BRANCH   = 'd8,
        S_ADDIEXEC = 'd9,
        S_ADDIWB   = 'd10
    } state_t;

    localparam logic [5:0] C_OP_LW     = 6'b100011;
    localparam logic [5:0] C_OP_SW     = 6'b101011;
    localparam logic [5:0] C_OP_RTYPE  = 6'b000000;
    localparam logic [5:0] C_OP_BEQ    = 6'b000100;
    localparam logic [5:0] C_OP_ADDI   = 6'b001000;

    localparam logic [5:0] C_FN_ADD    = 6'b100000;
    localparam logic [5:0] C_FN_SUB    = 6'b100010;
    localparam logic [5:0] C_FN_AND    = 6'b100100;
    localparam logic [5:0] C_FN_OR     = 6'b100101;
    localparam logic [5:0] C_FN_SLT    = 6'b101010;

    localparam logic [2:0] C_ALU_ADD   = 3'b010;
    localparam logic [2:0] C_ALU_SUB   = 3'b110;
    localparam logic [2:0] C_ALU_AND   = 3'b000;
    localparam logic [2:0] C_ALU_OR    = 3'b001;
    localparam logic [2:0] C_ALU_SLT   = 3'b111;

    state_t     state_q;
    state_t     state_d;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [2:0] w_alu_funct;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        w_alu_funct = C_ALU_ADD;
        case (funct)
            C_FN_ADD: w_alu_funct = C_ALU_ADD;
            C_FN_SUB: w_alu_funct = C_ALU_SUB;
            C_FN_AND: w_alu_funct = C_ALU_AND;
            C_FN_OR:  w_alu_funct = C_ALU_OR;
            C_FN_SLT: w_alu_funct = C_ALU_SLT;
            default:  w_alu_funct = C_ALU_ADD;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCsrc       = 1'b0;
        ALUControl  = C_ALU_ADD;
        illegal_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                ALUSrcB    = 2'b01;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target while the opcode is decoded
                ALUSrcB = 2'b11;
                case (op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE:       state_d = S_EXECUTE;
                    C_OP_BEQ:         state_d = S_BRANCH;
                    C_OP_ADDI:        state_d = S_ADDIEXEC;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_alu_funct;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = C_ALU_SUB;
                PCsrc      = 1'b1;
                w_branch   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Architectural write strobes are suppressed for the whole reset window
    assign PCen     = ~reset & (w_pc_write | (w_branch & zero));
    assign IRWrite  = ~reset & w_ir_write;
    assign MemWrite = ~reset & w_mem_write;
    assign RegWrite = ~reset & w_reg_write;
    assign state_o  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
//  Module      : tb_mips_multicycle_control
//  Description : Directed, table-driven self-checking bench for the control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCen;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCsrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic       illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_control #(.STATE_W(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .PCen       (PCen),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCsrc      (PCsrc),
        .ALUControl (ALUControl),
        .state_o    (state_o),
        .illegal_o  (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCen,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCsrc,ALUControl,illegal}
    logic [14:0] w_act;
    assign w_act = {PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, PCsrc, ALUControl, illegal_o};

    localparam logic [14:0] E_FETCH  = {8'b1001_0000, 2'b01, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_DECODE = {8'b0000_0000, 2'b11, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_ILLDEC = {8'b0000_0000, 2'b11, 1'b0, 3'b010, 1'b1};
    localparam logic [14:0] E_MEMADR = {8'b0000_0001, 2'b10, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_MEMRD  = {8'b0100_0000, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_MEMWB  = {8'b0000_0110, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_MEMWR  = {8'b0110_0000, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_ALUWB  = {8'b0000_1010, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_BR_TK  = {8'b1000_0001, 2'b00, 1'b1, 3'b110, 1'b0};
    localparam logic [14:0] E_BR_NT  = {8'b0000_0001, 2'b00, 1'b1, 3'b110, 1'b0};
    localparam logic [14:0] E_ADDIEX = {8'b0000_0001, 2'b10, 1'b0, 3'b010, 1'b0};
    localparam logic [14:0] E_ADDIWB = {8'b0000_0010, 2'b00, 1'b0, 3'b010, 1'b0};

    function automatic logic [14:0] e_exec(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 1'b0, alu, 1'b0};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    task automatic add(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] s, input logic [14:0] e);
        vecs[n_vec].name  = nm;
        vecs[n_vec].op    = o;
        vecs[n_vec].funct = f;
        vecs[n_vec].zero  = z;
        vecs[n_vec].st    = s;
        vecs[n_vec].exp   = e;
        n_vec++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rtype(input string nm, input logic [5:0] f, input logic [2:0] alu);
        add({nm, "_fetch"}, 6'b000000, f, 1'b0, 4'd0, E_FETCH);
        add({nm, "_decode"}, 6'b000000, f, 1'b0, 4'd1, E_DECODE);
        add({nm, "_exec"}, 6'b000000, f, 1'b0, 4'd6, e_exec(alu));
        add({nm, "_aluwb"}, 6'b000000, f, 1'b0, 4'd7, E_ALUWB);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lw: five cycles
        add("lw_fetch",  6'b100011, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("lw_decode", 6'b100011, 6'h00, 1'b0, 4'd1, E_DECODE);
        add("lw_memadr", 6'b100011, 6'h00, 1'b0, 4'd2, E_MEMADR);
        add("lw_memrd",  6'b100011, 6'h00, 1'b0, 4'd3, E_MEMRD);
        add("lw_memwb",  6'b100011, 6'h00, 1'b0, 4'd4, E_MEMWB);
        // sw: four cycles
        add("sw_fetch",  6'b101011, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("sw_decode", 6'b101011, 6'h00, 1'b0, 4'd1, E_DECODE);
        add("sw_memadr", 6'b101011, 6'h00, 1'b0, 4'd2, E_MEMADR);
        add("sw_memwr",  6'b101011, 6'h00, 1'b0, 4'd5, E_MEMWR);
        rtype("sub", 6'b100010, 3'b110);
        rtype("add", 6'b100000, 3'b010);
        rtype("and", 6'b100100, 3'b000);
        rtype("or",  6'b100101, 3'b001);
        rtype("slt", 6'b101010, 3'b111);
        rtype("unk", 6'b100111, 3'b010);
        // beq taken and not taken
        add("beqt_fetch",  6'b000100, 6'h00, 1'b1, 4'd0, E_FETCH);
        add("beqt_decode", 6'b000100, 6'h00, 1'b1, 4'd1, E_DECODE);
        add("beqt_branch", 6'b000100, 6'h00, 1'b1, 4'd8, E_BR_TK);
        add("beqn_fetch",  6'b000100, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("beqn_decode", 6'b000100, 6'h00, 1'b0, 4'd1, E_DECODE);
        add("beqn_branch", 6'b000100, 6'h00, 1'b0, 4'd8, E_BR_NT);
        // addi
        add("addi_fetch",  6'b001000, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("addi_decode", 6'b001000, 6'h00, 1'b0, 4'd1, E_DECODE);
        add("addi_exec",   6'b001000, 6'h00, 1'b0, 4'd9, E_ADDIEX);
        add("addi_wb",     6'b001000, 6'h00, 1'b0, 4'd10, E_ADDIWB);
        // unsupported opcodes: one DECODE cycle with illegal_o, then FETCH
        add("ill_fetch",   6'b111111, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("ill_decode",  6'b111111, 6'h00, 1'b0, 4'd1, E_ILLDEC);
        add("j_fetch",     6'b000010, 6'h00, 1'b0, 4'd0, E_FETCH);
        add("j_decode",    6'b000010, 6'h00, 1'b0, 4'd1, E_ILLDEC);
        add("post_fetch",  6'b000010, 6'h00, 1'b0, 4'd0, E_FETCH);

        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",   32'(state_o), 32'd0);
        check("rst_PCen",    32'(PCen), 32'd0);
        check("rst_IRWrite", 32'(IRWrite), 32'd0);
        check("rst_ALUSrcB", 32'(ALUSrcB), 32'd1);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < n_vec; i++) begin
            if (i != 0) @(negedge clk);
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            #1;
            check({vecs[i].name, "_state"}, 32'(state_o), 32'(vecs[i].st));
            check({vecs[i].name, "_outs"}, 32'(w_act), 32'(vecs[i].exp));
            check({vecs[i].name, "_one_wr"},
                  32'($countones({MemWrite, RegWrite, IRWrite}) <= 1), 32'd1);
        end

        // Reset pulse landing in MEMWB of a lw
        @(negedge clk);
        op    = 6'b100011;
        zero  = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rmw_pre_state", 32'(state_o), 32'd4);
        check("rmw_pre_RegWrite", 32'(RegWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rmw_state",    32'(state_o), 32'd0);
        check("rmw_RegWrite", 32'(RegWrite), 32'd0);
        check("rmw_PCen",     32'(PCen), 32'd0);
        check("rmw_IRWrite",  32'(IRWrite), 32'd0);
        check("rmw_ALUSrcB",  32'(ALUSrcB), 32'd1);
        @(negedge clk);
        #1;
        check("rmw_hold_state", 32'(state_o), 32'd0);
        reset = 1'b0;
        #1;
        check("rmw_rel_IRWrite", 32'(IRWrite), 32'd1);
        check("rmw_rel_PCen",    32'(PCen), 32'd1);
        @(negedge clk);
        #1;
        check("rmw_rel_decode", 32'(state_o), 32'd1);

        // Reset pulse landing in MEMWR of a sw
        op = 6'b101011;
        repeat (2) @(negedge clk);
        #1;
        check("rsw_pre_MemWrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rsw_MemWrite", 32'(MemWrite), 32'd0);
        check("rsw_state",    32'(state_o), 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
